// File: rtl/lb_master.sv
// lb_master: local-bus initiator issuing single rd/wr pulses, waiting for strobe with timeout.
// Optional retry-on-first-timeout enabled by defining LB_MASTER_RETRY_EN.
module lb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        lb_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [15:0] lb_addr,
  output logic [15:0] lb_data_out,
  output logic        lb_rd,
  output logic        lb_wr,
  input  logic [15:0] lb_data_in,
  input  logic        lb_strb_all,
  output logic        timeout
);
`ifdef LB_MASTER_RETRY_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, REISSUE} state_t;
  logic [15:0] r_data;
  logic        r_retry;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif
  localparam logic [TIMEOUT_W-1:0] W_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_wr;
  always_ff @(posedge lb_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      cmd_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      lb_addr     <= '0;
      lb_data_out <= '0;
      lb_rd       <= 1'b0;
      lb_wr       <= 1'b0;
      timeout     <= 1'b0;
`ifdef LB_MASTER_RETRY_EN
      r_data      <= '0;
      r_retry     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            r_wr        <= cmd_wr;
            lb_addr     <= cmd_addr;
            lb_rd       <= ~cmd_wr;
            lb_wr       <= cmd_wr;
            lb_data_out <= cmd_wr ? cmd_data : '0;
`ifdef LB_MASTER_RETRY_EN
            r_data      <= cmd_data;
            r_retry     <= 1'b0;
`endif
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          lb_rd       <= 1'b0;
          lb_wr       <= 1'b0;
          lb_data_out <= '0;
          r_cnt       <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (lb_strb_all) begin
            resp_valid <= 1'b1;
            resp_data  <= r_wr ? '0 : lb_data_in;
            resp_err   <= 1'b0;
            r_state    <= RESP;
          end else if (r_cnt == W_LAST) begin
`ifdef LB_MASTER_RETRY_EN
            if (!r_retry) begin
              timeout <= 1'b1;
              r_retry <= 1'b1;
              r_state <= REISSUE;
            end else
`endif
            begin
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_err   <= 1'b1;
              timeout    <= 1'b1;
              r_state    <= RESP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            timeout    <= 1'b0;
            cmd_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
`ifdef LB_MASTER_RETRY_EN
        REISSUE: begin
          timeout     <= 1'b0;
          lb_rd       <= ~r_wr;
          lb_wr       <= r_wr;
          lb_data_out <= r_wr ? r_data : '0;
          r_state     <= ISSUE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lb_master.sv
// tb_lb_master: randomized and directed transactions checked against a cycle-timeline model of the bus master.
module tb_lb_master;
  localparam int T = 16;
  logic        lb_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, resp_ready = 1'b0, lb_strb_all = 1'b0;
  logic [15:0] cmd_addr = '0, cmd_data = '0, lb_data_in = '0;
  logic        cmd_ready, resp_valid, resp_err, lb_rd, lb_wr, timeout;
  logic [15:0] resp_data, lb_addr, lb_data_out;
  int total = 0, bad = 0;

  lb_master #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
    .lb_clk(lb_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err), .lb_addr(lb_addr),
    .lb_data_out(lb_data_out), .lb_rd(lb_rd), .lb_wr(lb_wr), .lb_data_in(lb_data_in),
    .lb_strb_all(lb_strb_all), .timeout(timeout)
  );

  always #5 lb_clk = ~lb_clk;

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Timeline relative to the command: cycle 0 is the first bus pulse, s is the cycle the strobe
  // is presented, rd is how many cycles the response waits for resp_ready.
  task automatic run(input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] din, input int s, input int rd);
    int rc, hs, p2, k;
    logic ok1, ok2, err, pulse, exp_to, in_resp;
    ok1 = (s >= 1) && (s <= T);
`ifdef LB_MASTER_RETRY_EN
    ok2 = !ok1 && (s >= T + 3) && (s <= 2 * T + 2);
    p2  = ok1 ? -1 : T + 2;
    rc  = (ok1 || ok2) ? s + 1 : 2 * T + 3;
`else
    ok2 = 1'b0;
    p2  = -1;
    rc  = ok1 ? s + 1 : T + 1;
`endif
    err = !(ok1 || ok2);
    hs  = rc + rd;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge lb_clk);
      k++;
    end
    chk("cmd_ready_wait", {15'd0, cmd_ready}, 16'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge lb_clk);
    cmd_valid = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_data  = 16'($urandom);
    cmd_wr    = 1'($urandom);
    for (int n = 0; n <= hs + 1; n++) begin
      pulse   = (n == 0) || (n == p2);
      in_resp = (n >= rc) && (n <= hs);
`ifdef LB_MASTER_RETRY_EN
      exp_to  = err ? ((n == T + 1) || ((n >= 2 * T + 3) && (n <= hs))) : (ok2 && (n == T + 1));
`else
      exp_to  = err && (n >= T + 1) && (n <= hs);
`endif
      chk("lb_rd", {15'd0, lb_rd}, {15'd0, pulse & ~wr});
      chk("lb_wr", {15'd0, lb_wr}, {15'd0, pulse & wr});
      chk("lb_data_out", lb_data_out, (pulse && wr) ? d : 16'd0);
      chk("lb_addr", lb_addr, a);
      chk("timeout", {15'd0, timeout}, {15'd0, exp_to});
      chk("resp_valid", {15'd0, resp_valid}, {15'd0, in_resp});
      chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, n > hs});
      if (in_resp) begin
        chk("resp_data", resp_data, (err || wr) ? 16'd0 : din);
        chk("resp_err", {15'd0, resp_err}, {15'd0, err});
      end
      lb_strb_all = (n == s);
      lb_data_in  = (n == s) ? din : 16'($urandom);
      resp_ready  = (n == hs) ? 1'b1 : 1'($urandom) & (n < rc);
      @(negedge lb_clk);
    end
    lb_strb_all = 1'b0;
    lb_data_in  = '0;
    resp_ready  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge lb_clk);
    chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
    chk("rst_resp_err", {15'd0, resp_err}, 16'd0);
    chk("rst_resp_data", resp_data, 16'd0);
    chk("rst_lb_addr", lb_addr, 16'd0);
    chk("rst_lb_data_out", lb_data_out, 16'd0);
    chk("rst_lb_rd", {15'd0, lb_rd}, 16'd0);
    chk("rst_lb_wr", {15'd0, lb_wr}, 16'd0);
    chk("rst_timeout", {15'd0, timeout}, 16'd0);
    reset = 1'b0;
    @(negedge lb_clk);
    chk("post_rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    run(1'b0, 16'h0100, 16'h5555, 16'hBEEF, 1, 0);
    run(1'b1, 16'h0042, 16'h1234, 16'hFFFF, 3, 0);
    run(1'b0, 16'h0200, 16'h0000, 16'h1111, 1000, 5);
    run(1'b0, 16'h0300, 16'h0000, 16'h00AA, T, 0);
    run(1'b0, 16'h0400, 16'h0000, 16'h7777, T + 3, 4);
    run(1'b0, 16'h0500, 16'h0000, 16'h2468, 2, 1);
    run(1'b1, 16'h0600, 16'hCAFE, 16'h0000, T + 5, 0);
    run(1'b1, 16'h0700, 16'hD00D, 16'h0000, 1000, 2);
    run(1'b0, 16'h0800, 16'h0000, 16'hABCD, 0, 0);
    // reset while waiting for a strobe: nothing may come back
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 16'h0900;
    @(negedge lb_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge lb_clk);
    reset       = 1'b1;
    lb_strb_all = 1'b1;
    lb_data_in  = 16'h4242;
    resp_ready  = 1'b1;
    @(negedge lb_clk);
    chk("midrst_resp_valid", {15'd0, resp_valid}, 16'd0);
    chk("midrst_lb_rd", {15'd0, lb_rd}, 16'd0);
    chk("midrst_lb_wr", {15'd0, lb_wr}, 16'd0);
    chk("midrst_timeout", {15'd0, timeout}, 16'd0);
    chk("midrst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
    chk("midrst_lb_addr", lb_addr, 16'd0);
    reset       = 1'b0;
    lb_strb_all = 1'b0;
    resp_ready  = 1'b0;
    @(negedge lb_clk);
    chk("midrst_cmd_ready_after", {15'd0, cmd_ready}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_resp", {15'd0, resp_valid}, 16'd0);
      @(negedge lb_clk);
    end
    run(1'b0, 16'h0A00, 16'h0000, 16'h1357, 4, 0);
    for (int i = 0; i < 40; i++)
      run(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 2 * T + 6), $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lb_master.md
Name: lb_master

Overview:
- Local-bus initiator: accepts single read/write commands from an upstream command source over a valid/ready handshake.
- Issues each command on the shared local bus as a one-cycle lb_rd/lb_wr pulse, then waits for the OR'd slave strobe.
- Returns read data or an error flag over a valid/ready response handshake.
- Owns the bus-timeout function: drives the timeout line consumed by the bus monitor and other observers.

Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before a transaction is declared timed out (legal range 2..2^TIMEOUT_W-1).
- TIMEOUT_W, 8, width of the wait counter.

Ports:
- lb_clk  in  1  bus clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  16  target address.
- cmd_data  in  16  write data (ignored for reads).
- resp_valid  out  1  response present.
- resp_ready  in  1  upstream accepts response.
- resp_data  out  16  read data; 0 for writes and errors.
- resp_err  out  1  1 = transaction timed out.
- lb_addr  out  16  bus address.
- lb_data_out  out  16  bus write data.
- lb_rd  out  1  read pulse.
- lb_wr  out  1  write pulse.
- lb_data_in  in  16  OR'd slave read data.
- lb_strb_all  in  1  OR of all slave strobes.
- timeout  out  1  bus timeout indication.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 the cycle after; resp_valid=0, resp_err=0, resp_data=0, lb_addr=0, lb_data_out=0, lb_rd=0, lb_wr=0, timeout=0. State=IDLE, counter=0.
- Reset mid-transaction: the pending transaction is discarded, no response is produced, and all outputs return to their reset values the next cycle.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_wr, cmd_addr and cmd_data; go to ISSUE.
- ISSUE (exactly one cycle):
  - lb_addr=latched addr.
  - lb_rd=~wr and lb_wr=wr.
  - lb_data_out=data if write, else 0.
  - cmd_ready=0.
  - Go to WAIT with counter=0.
- WAIT:
  - lb_rd=lb_wr=0.
  - lb_addr held at the latched addr; lb_data_out=0.
  - Each cycle without lb_strb_all, counter increments.
  - If lb_strb_all: resp_data=lb_data_in for reads, 0 for writes; resp_err=0; go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: resp_err=1, resp_data=0, timeout=1; go to RESP.
  - Strobe and expiry in the same cycle: the strobe wins, so no timeout is raised.
  - First legal strobe arrives in the first WAIT cycle, because slaves register strb.
  - Maximum WAIT duration = TIMEOUT_CYCLES cycles.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable until resp_valid&resp_ready.
  - On that handshake: resp_valid=0, timeout=0, go to IDLE.
  - timeout is asserted from expiry until the response handshake, so it is high for at least 1 cycle.
- lb_strb_all is ignored in IDLE, ISSUE and RESP. A late strobe after a timeout has no effect.
- lb_addr retains its last value in IDLE. It changes only in ISSUE.
- Back-to-back throughput: one command accepted per IDLE cycle. The minimum transaction is 4 cycles (IDLE→ISSUE→WAIT→RESP), with resp_ready tied high.

Optional Feature:
- Macro: LB_MASTER_RETRY_EN.
- With the macro defined, the first timeout of a transaction does not go to RESP:
  - timeout=1 for exactly one cycle (state REISSUE).
  - Next cycle: timeout=0 and ISSUE repeats with identical addr/cmd/data.
  - A second expiry sets resp_err=1 and timeout=1, held until the response handshake, as in the base behaviour.
  - A strobe during the retry completes normally with resp_err=0.
- The guaranteed low cycle on timeout between the two expiries lets edge-qualified observers count both.
- Without the macro: no REISSUE state; the first expiry goes straight to RESP with an error.

Test Plan:
1. Read 0x0100; slave strobes 1 cycle after lb_rd with lb_data_in=0xBEEF → lb_rd pulses exactly 1 cycle with lb_addr=0x0100; response resp_data=0xBEEF, resp_err=0; timeout stays 0.
2. Write 0x0042 data 0x1234; strobe on the 3rd WAIT cycle → lb_wr=1 and lb_data_out=0x1234 for 1 cycle only; response resp_data=0, resp_err=0.
3. Read with no strobe, TIMEOUT_CYCLES=16 → exactly 16 WAIT cycles, then timeout=1 with resp_err=1, resp_data=0. Hold resp_ready low 5 cycles: timeout and resp_valid stay high, and both drop the cycle after the handshake.
4. Strobe coincident with expiry (16th WAIT cycle), lb_data_in=0x00AA → resp_err=0, resp_data=0x00AA, timeout never asserted. A strobe arriving 2 cycles after a timeout → ignored, and the next command issues normally.
5. Assert reset during WAIT of a read → no resp_valid; lb_rd, lb_wr and timeout low; cmd_ready=1 on the cycle after reset deasserts; a new command completes normally.
6. With LB_MASTER_RETRY_EN and no strobe → two lb_rd pulses at the same address; timeout goes high 1 cycle, low ≥1 cycle, then high until the handshake; resp_err=1. A strobe during the retry → resp_err=0.
